// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - E-stage MDU operand/result bundle
// The pipeline side drives master; the MDU implements slave.
interface e_mdu_if;
  logic [3:0]  E_MDU_op;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic        D_MDU_use;
  logic [31:0] E_MDU_result;
  logic        MDU_busy;
  logic        MDU_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_MDU_op, E_rs_data, E_rt_data, D_MDU_use,
    input  E_MDU_result, MDU_busy, MDU_stall, HI, LO
  );

  modport slave (
    input  E_MDU_op, E_rs_data, E_rt_data, D_MDU_use,
    output E_MDU_result, MDU_busy, MDU_stall, HI, LO
  );
endinterface

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle multiply/divide unit with HI/LO registers
// The result is computed at start and held until the busy counter expires.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  e_mdu_if.slave   bus
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_hi, r_lo, r_res_hi, r_res_lo;
  logic            r_commit;
  logic [CW-1:0]   r_cnt;
  logic            w_busy, w_is_mul, w_is_div, w_start, w_done;
  logic [31:0]     w_a, w_b;
  logic [63:0]     w_mul_a, w_mul_b, w_prod;
  logic            w_a_neg, w_b_neg, w_b_nz;
  logic [31:0]     w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_q, w_r;

  assign w_a      = bus.E_rs_data;
  assign w_b      = bus.E_rt_data;
  assign w_busy   = (r_state == S_BUSY);
  assign w_is_mul = (bus.E_MDU_op == OP_MULT) || (bus.E_MDU_op == OP_MULTU);
  assign w_is_div = (bus.E_MDU_op == OP_DIV)  || (bus.E_MDU_op == OP_DIVU);
  assign w_start  = (w_is_mul || w_is_div) && !w_busy;

  // Sign-extending for MULT lets one 64-bit multiplier serve both flavours.
  assign w_mul_a = (bus.E_MDU_op == OP_MULT) ? {{32{w_a[31]}}, w_a} : {32'd0, w_a};
  assign w_mul_b = (bus.E_MDU_op == OP_MULT) ? {{32{w_b[31]}}, w_b} : {32'd0, w_b};
  assign w_prod  = w_mul_a * w_mul_b;

  // Signed divide on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
  assign w_a_neg = (bus.E_MDU_op == OP_DIV) && w_a[31];
  assign w_b_neg = (bus.E_MDU_op == OP_DIV) && w_b[31];
  assign w_b_nz  = (w_b != 32'd0);
  assign w_a_mag = w_a_neg ? (~w_a + 32'd1) : w_a;
  assign w_b_mag = w_b_neg ? (~w_b + 32'd1) : w_b;
  assign w_q_mag = w_b_nz ? (w_a_mag / w_b_mag) : 32'd0;
  assign w_r_mag = w_b_nz ? (w_a_mag % w_b_mag) : 32'd0;
  assign w_q     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r     = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_BUSY;
      S_BUSY: if (r_cnt == '0) begin
        w_state_nxt = S_IDLE;
        w_done      = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_commit <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_start) begin
        r_cnt    <= w_is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
        r_res_hi <= w_is_mul ? w_prod[63:32] : w_r;
        r_res_lo <= w_is_mul ? w_prod[31:0]  : w_q;
        r_commit <= w_is_mul || w_b_nz;
      end else if (w_busy && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_done && r_commit) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end else if (!w_busy) begin
        if (bus.E_MDU_op == OP_MTHI) r_hi <= w_a;
        if (bus.E_MDU_op == OP_MTLO) r_lo <= w_a;
      end
    end
  end

  assign bus.E_MDU_result = (bus.E_MDU_op == OP_MFHI) ? r_hi :
                            (bus.E_MDU_op == OP_MFLO) ? r_lo : 32'd0;
  assign bus.MDU_busy  = w_busy;
  assign bus.MDU_stall = bus.D_MDU_use && (w_start || w_busy);
  assign bus.HI        = r_hi;
  assign bus.LO        = r_lo;
endmodule
